// File: rtl/alu_seq_pkg.sv
// Shared op-codes, FSM encodings and helpers for the
// nibble-serial ALU sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_CLR   = 3'b000;
  localparam logic [2:0] OP_BSUBA = 3'b001;
  localparam logic [2:0] OP_ASUBB = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_AND   = 3'b110;
  localparam logic [2:0] OP_SET   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_BSUBA) ||
           (op == OP_ASUBB) ||
           (op == OP_ADD);
  endfunction

endpackage

// File: rtl/nibble_carry.sv
// Rebuilds the inter-nibble carry/borrow from the
// slice's active-low generate/propagate outputs.
module nibble_carry (
  input  logic gn,
  input  logic pn,
  input  logic cin,
  input  logic arith,
  output logic cout
);

  assign cout = arith & (~gn | (~pn & cin));

endmodule

// File: rtl/nibble_alu_sequencer.sv
// Drives a 4-bit 74x381-style ALU slice one nibble per
// clock to perform a WIDTH-bit operation, LSB first.
module nibble_alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic [2:0]       slice_s,
  output logic             slice_cn,
  input  logic [3:0]       slice_f,
  input  logic             slice_gn,
  input  logic             slice_pn
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [2:0]      r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [IW+1:0]   w_sh;
  logic            w_last;
  logic            w_cout;

  assign w_sh   = {r_idx, 2'b00};
  assign w_last = (r_idx == LAST);

  nibble_carry u_carry (
    .gn    (slice_gn),
    .pn    (slice_pn),
    .cin   (r_carry),
    .arith (is_arith(r_op)),
    .cout  (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Slice pins idle at zero outside RUN so the slice is deterministic.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_s   = OP_CLR;
    slice_cn  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = ST_RUN;
      end
      ST_RUN: begin
        slice_a  = r_a[w_sh +: 4];
        slice_b  = r_b[w_sh +: 4];
        slice_s  = r_op;
        slice_cn = r_carry;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_op    <= OP_CLR;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_a     <= req_a;
        r_b     <= req_b;
        r_op    <= req_op;
        r_idx   <= '0;
        r_carry <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_res[w_sh +: 4] <= slice_f;
        r_carry          <= w_cout;
        r_idx            <= w_last ? '0 : r_idx + IW'(1);
      end
    end
  end

  assign rsp_f    = r_res;
  assign rsp_cout = r_carry;
  assign rsp_zero = (r_res == '0);

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// Self-checking bench: sequencer driving a behavioural
// 74x381 slice, directed vector table plus corner sequences.
module tb_nibble_alu_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = 3'b000;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_f;
  logic         rsp_cout;
  logic         rsp_zero;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic [2:0]   slice_s;
  logic         slice_cn;
  logic [3:0]   slice_f;
  logic         slice_gn;
  logic         slice_pn;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_alu_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_f     (rsp_f),
    .rsp_cout  (rsp_cout),
    .rsp_zero  (rsp_zero),
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_s   (slice_s),
    .slice_cn  (slice_cn),
    .slice_f   (slice_f),
    .slice_gn  (slice_gn),
    .slice_pn  (slice_pn)
  );

  // 74x381 slice model; cn adds on A+B and borrows on subtracts.
  always_comb begin
    logic [4:0] t;
    t        = 5'd0;
    slice_f  = 4'h0;
    slice_gn = 1'b1;
    slice_pn = 1'b1;
    case (slice_s)
      3'b000: slice_f = 4'h0;
      3'b001: begin
        t        = {1'b0, slice_b} - {1'b0, slice_a} - {4'h0, slice_cn};
        slice_f  = t[3:0];
        slice_gn = (slice_b < slice_a) ? 1'b0 : 1'b1;
        slice_pn = (slice_b == slice_a) ? 1'b0 : 1'b1;
      end
      3'b010: begin
        t        = {1'b0, slice_a} - {1'b0, slice_b} - {4'h0, slice_cn};
        slice_f  = t[3:0];
        slice_gn = (slice_a < slice_b) ? 1'b0 : 1'b1;
        slice_pn = (slice_a == slice_b) ? 1'b0 : 1'b1;
      end
      3'b011: begin
        t        = {1'b0, slice_a} + {1'b0, slice_b};
        slice_gn = t[4] ? 1'b0 : 1'b1;
        slice_pn = (t == 5'd15) ? 1'b0 : 1'b1;
        t        = t + {4'h0, slice_cn};
        slice_f  = t[3:0];
      end
      3'b100: slice_f = slice_a ^ slice_b;
      3'b101: slice_f = slice_a | slice_b;
      3'b110: slice_f = slice_a & slice_b;
      default: slice_f = 4'hF;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] f;
    logic        cout;
    logic        zero;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    vecs[0] = '{3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
    vecs[1] = '{3'b010, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[2] = '{3'b001, 32'h00000005, 32'h00000007, 32'h00000002, 1'b0, 1'b0};
    vecs[3] = '{3'b100, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 1'b0, 1'b0};
    vecs[4] = '{3'b111, 32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[5] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1};
    vecs[6] = '{3'b110, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h05050505, 1'b0, 1'b0};
    vecs[7] = '{3'b101, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAFAFAFAF, 1'b0, 1'b0};
    vecs[8] = '{3'b011, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0};
    vecs[9] = '{3'b010, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_f", rsp_f, 32'd0);
    chk("rst_rsp_cout", {31'd0, rsp_cout}, 32'd0);
    chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd1);
    chk("rst_slice", {20'd0, slice_a, slice_b, slice_s, slice_cn},
        32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      chk($sformatf("lat[%0d]", i), lat, 32'd8);
      chk($sformatf("f[%0d]", i), rsp_f, vecs[i].f);
      chk($sformatf("cout[%0d]", i), {31'd0, rsp_cout},
          {31'd0, vecs[i].cout});
      chk($sformatf("zero[%0d]", i), {31'd0, rsp_zero},
          {31'd0, vecs[i].zero});
      handshake();
      chk($sformatf("idle[%0d]", i), {30'd0, req_ready, rsp_valid},
          32'd2);
    end

    // Back-to-back with backpressure: second request held pending.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'b011;
    req_a     = 32'h0F0F0F0F;
    req_b     = 32'h01010101;
    @(posedge clk);
    @(negedge clk);
    req_op = 3'b010;
    req_a  = 32'h00000000;
    req_b  = 32'h00000001;
    chk("b2b_busy", {31'd0, req_ready}, 32'd0);
    wait_valid(lat);
    chk("b2b_lat1", lat, 32'd8);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_valid[%0d]", c), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp_f[%0d]", c), rsp_f, 32'h10101010);
      chk($sformatf("bp_ready[%0d]", c), {31'd0, req_ready}, 32'd0);
    end
    chk("bp_cout", {31'd0, rsp_cout}, 32'd0);
    handshake();
    chk("b2b_idle", {30'd0, req_ready, rsp_valid}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_accept2", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    wait_valid(lat);
    chk("b2b_lat2", lat, 32'd8);
    chk("b2b_f2", rsp_f, 32'hFFFFFFFF);
    chk("b2b_cout2", {31'd0, rsp_cout}, 32'd1);
    handshake();

    // Reset mid-RUN at nibble index 3.
    send(3'b011, 32'hABCDEF01, 32'h11111111);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_slice_a", {28'd0, slice_a}, 32'hE);
    chk("mid_slice_s", {29'd0, slice_s}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ready_valid", {30'd0, req_ready, rsp_valid}, 32'd2);
    chk("arst_f", rsp_f, 32'd0);
    chk("arst_cout_zero", {30'd0, rsp_cout, rsp_zero}, 32'd1);
    chk("arst_slice", {20'd0, slice_a, slice_b, slice_s, slice_cn},
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) lat++;
    end
    chk("no_stale_rsp", lat, 32'd0);
    send(3'b011, 32'h12345678, 32'h11111111);
    wait_valid(lat);
    chk("post_rst_lat", lat, 32'd8);
    chk("post_rst_f", rsp_f, 32'h23456789);
    chk("post_rst_cout", {31'd0, rsp_cout}, 32'd0);
    chk("post_rst_zero", {31'd0, rsp_zero}, 32'd0);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
